// File: rtl/texel_serializer.sv
// Captures one 168-bit triangle and streams it as FRAME_START followed by six
// 32-bit payload words (LSW first); optionally emits a FRAME_END marker.
module texel_serializer #(
  parameter logic [31:0] FRAME_START = 32'd0,
  parameter logic [31:0] FRAME_END   = 32'd1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [167:0] texel_buffer,
  input  logic         texel_valid,
  output logic         texel_read,
  input  logic         frame_end_req,
  output logic         frame_end_ack,
  output logic [31:0]  ahb_word,
  output logic         ahb_word_valid,
  input  logic         ahb_word_ready,
  output logic         busy
);

  localparam int unsigned NUM_WORDS = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     count_q, count_d;
  logic [167:0]   cap_q, cap_d;
  logic           read_d;
  logic           ack_d;
  logic [31:0]    word_w [NUM_WORDS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_word
      assign word_w[gi] = cap_q[32*gi +: 32];
    end
  endgenerate
  assign word_w[NUM_WORDS-1] = {24'h0, cap_q[167:160]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cap_q   <= cap_d;
    end
  end

  // Next-state logic; every non-IDLE state presents a valid word, so the
  // ready input alone marks a transfer.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cap_d   = cap_q;
    read_d  = 1'b0;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (texel_valid) begin
          read_d  = 1'b1;
          cap_d   = texel_buffer;
          count_d = '0;
          state_d = S_HDR;
        end else if (frame_end_req) begin
          state_d = S_END;
        end
      end
      S_HDR: begin
        if (ahb_word_ready) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ahb_word_ready) begin
          if (count_q >= 3'd5) begin
            count_d = '0;
            state_d = S_IDLE;
          end else begin
            count_d = count_q + 3'd1;
          end
        end
      end
      S_END: begin
        if (ahb_word_ready) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output word decodes from registered state only.
  always_comb begin
    ahb_word       = '0;
    ahb_word_valid = 1'b0;
    case (state_q)
      S_HDR: begin
        ahb_word       = FRAME_START;
        ahb_word_valid = 1'b1;
      end
      S_DATA: begin
        ahb_word_valid = 1'b1;
        case (count_q)
          3'd0:    ahb_word = word_w[0];
          3'd1:    ahb_word = word_w[1];
          3'd2:    ahb_word = word_w[2];
          3'd3:    ahb_word = word_w[3];
          3'd4:    ahb_word = word_w[4];
          3'd5:    ahb_word = word_w[5];
          default: ahb_word = '0;
        endcase
      end
      S_END: begin
        ahb_word       = FRAME_END;
        ahb_word_valid = 1'b1;
      end
      default: begin
        ahb_word       = '0;
        ahb_word_valid = 1'b0;
      end
    endcase
  end

  // Pulses are forced low while reset is asserted, even though IDLE is live.
  assign texel_read    = read_d & n_rst;
  assign frame_end_ack = ack_d & n_rst;
  assign busy          = (state_q != S_IDLE);

endmodule
